// File: rtl/wb_sram_slave.sv
// Wishbone classic slave bridging to an asynchronous SRAM.
// Every output and the data-bus drive enable come straight from flops.
module wb_sram_slave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int SRAM_DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    output logic                         wb_ack_o,
    input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
    input  logic                         wb_we_i,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    inout  logic [SRAM_DATA_WIDTH-1:0]   sram_data,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_READ_2, S_WRITE, S_WRITE_2, S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic                         ack_q, ack_d;
    logic [DATA_WIDTH-1:0]        dat_o_q, dat_o_d;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                         ce_n_q, ce_n_d;
    logic                         oe_n_q, oe_n_d;
    logic                         we_n_q, we_n_d;
    logic [SRAM_DATA_WIDTH/8-1:0] be_n_q, be_n_d;
    logic [SRAM_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                         drive_q, drive_d;

    // Byte-lane bits and bits above the SRAM window never affect the access.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        dat_o_d = dat_o_q;
        addr_d  = addr_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        be_n_d  = be_n_q;
        wdata_d = wdata_q;
        drive_d = drive_q;
        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d  = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                    be_n_d  = ~wb_sel_i;
                    ce_n_d  = 1'b0;
                    wdata_d = wb_dat_i;
                    if (wb_we_i) begin
                        state_d = S_WRITE;
                        drive_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            S_READ:    state_d = S_READ_2;
            S_READ_2: begin
                dat_o_d = sram_data;
                ack_d   = 1'b1;
                oe_n_d  = 1'b1;
                ce_n_d  = 1'b1;
                state_d = S_DONE;
            end
            S_WRITE: begin
                we_n_d  = 1'b0;
                state_d = S_WRITE_2;
            end
            S_WRITE_2: begin
                we_n_d  = 1'b1;
                ce_n_d  = 1'b1;
                ack_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                ack_d   = 1'b0;
                drive_d = 1'b0;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase

        // Losing the cycle mid-access overrides whatever the state above chose.
        if (!wb_cyc_i && state_q inside {S_READ, S_READ_2, S_WRITE, S_WRITE_2}) begin
            state_d = S_IDLE;
            dat_o_d = dat_o_q;
            ack_d   = 1'b0;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            drive_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
            addr_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= '1;
            wdata_q <= '0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
            addr_q  <= addr_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            wdata_q <= wdata_d;
            drive_q <= drive_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_o_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_be_n = be_n_q;
    assign sram_data = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave with a behavioural async SRAM on a pulled-up bus.
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    logic [31:0] mem [0:255];
    logic        mdl_oe;

    always #5 clk = ~clk;

    wb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_ADDR_WIDTH(20), .SRAM_DATA_WIDTH(32)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    // An undriven bus floats to all ones through the pullups.
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup pu (sram_data[g]);
    end

    assign mdl_oe    = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_data = mdl_oe ? mem[sram_addr[7:0]] : 'z;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!sram_oe_n && !sram_we_n) begin
                errors++;
                $display("FAIL strobe_overlap: oe_n=%b we_n=%b, required not both 0", sram_oe_n, sram_we_n);
            end
            checks++;
            if (!mdl_oe && !((!sram_ce_n && sram_oe_n) || wb_ack_o) && sram_data !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL bus_release: sram_data=%h, required high-Z (ffffffff)", sram_data);
            end
        end
    end

    int          edges, oe_cnt, we_cnt;
    logic [31:0] rdata;
    logic [19:0] a_seen;
    logic [3:0]  be_seen;
    logic        ack_after;

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        edges = 0; oe_cnt = 0; we_cnt = 0; rdata = '0; a_seen = '0; be_seen = '1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin a_seen = sram_addr; be_seen = sram_be_n; end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (wb_ack_o) begin edges = i; rdata = wb_dat_o; break; end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        ack_after = wb_ack_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wb_ack_o, sram_ce_n, sram_oe_n, sram_we_n} !== 4'b0111) begin
            errors++;
            $display("FAIL reset_strobes: ack,ce,oe,we=%b, required 0111", {wb_ack_o, sram_ce_n, sram_oe_n, sram_we_n});
        end
        checks++;
        if (wb_dat_o !== 32'h0 || sram_addr !== 20'h0 || sram_be_n !== 4'hF) begin
            errors++;
            $display("FAIL reset_regs: dat_o=%h addr=%h be_n=%h, required 0 0 f", wb_dat_o, sram_addr, sram_be_n);
        end
        checks++;
        if (sram_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_bus: sram_data=%h, required high-Z", sram_data);
        end
        rst_i = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_read();
        wb_cycle(1'b0, 32'h8000_0040, 32'h0, 4'hF);
        checks++;
        if (a_seen !== 20'h00010 || be_seen !== 4'h0) begin
            errors++;
            $display("FAIL read_addr: addr=%h be_n=%h, required 00010 0", a_seen, be_seen);
        end
        checks++;
        if (edges !== 3 || oe_cnt !== 2) begin
            errors++;
            $display("FAIL read_timing: ack_edge=%0d oe_low=%0d, required 3 2", edges, oe_cnt);
        end
        checks++;
        if (rdata !== 32'hDEAD_BEEF || ack_after !== 1'b0) begin
            errors++;
            $display("FAIL read_data: dat_o=%h ack_after=%b, required deadbeef 0", rdata, ack_after);
        end
        wb_cycle(1'b0, 32'hFFC0_0043, 32'h0, 4'hF);
        checks++;
        if (a_seen !== 20'h00010 || rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_alias: addr=%h dat_o=%h, required 00010 deadbeef", a_seen, rdata);
        end
    endtask

    task automatic test_byte_write();
        wb_adr_i = 32'h8000_0044; wb_dat_i = 32'h0000_00AB; wb_sel_i = 4'h1; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b0 || sram_data !== 32'h0000_00AB || sram_be_n !== 4'hE) begin
            errors++;
            $display("FAIL write_pulse: we_n=%b data=%h be_n=%h, required 0 000000ab e", sram_we_n, sram_data, sram_be_n);
        end
        @(negedge clk);
        checks++;
        if (wb_ack_o !== 1'b1 || sram_we_n !== 1'b1 || sram_data !== 32'h0000_00AB) begin
            errors++;
            $display("FAIL write_hold: ack=%b we_n=%b data=%h, required 1 1 000000ab", wb_ack_o, sram_we_n, sram_data);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_ack_o !== 1'b0 || sram_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL write_release: ack=%b data=%h, required 0 high-Z", wb_ack_o, sram_data);
        end
        checks++;
        if (wb_dat_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_keeps_dat_o: dat_o=%h, required deadbeef", wb_dat_o);
        end
        wb_cycle(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        checks++;
        if (rdata !== 32'h1122_33AB || edges !== 3) begin
            errors++;
            $display("FAIL write_readback: dat_o=%h ack_edge=%0d, required 112233ab 3", rdata, edges);
        end
    endtask

    task automatic test_sel_zero();
        wb_cycle(1'b1, 32'h0000_004C, 32'h5555_5555, 4'h0);
        checks++;
        if (edges !== 3 || we_cnt !== 1 || be_seen !== 4'hF) begin
            errors++;
            $display("FAIL sel_zero: ack_edge=%0d we_low=%0d be_n=%h, required 3 1 f", edges, we_cnt, be_seen);
        end
        checks++;
        if (mem[8'h13] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL sel_zero_mem: mem=%h, required 0badf00d", mem[8'h13]);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int pos1 = 0;
        int pos2 = 0;
        logic prev = 1'b0;
        logic dbl = 1'b0;
        wb_adr_i = 32'h0000_0040; wb_sel_i = 4'hF; wb_we_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (wb_ack_o && prev) dbl = 1'b1;
            prev = wb_ack_o;
            if (wb_ack_o) begin
                acks++;
                if (acks == 1) pos1 = i; else pos2 = i;
                wb_stb_i = 1'b0;
            end else if (acks < 2) begin
                wb_stb_i = 1'b1;
            end else begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
        checks++;
        if (acks !== 2 || dbl !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: acks=%0d double=%b, required 2 0", acks, dbl);
        end
        checks++;
        if (pos1 !== 3 || pos2 !== 7) begin
            errors++;
            $display("FAIL b2b_spacing: ack cycles=%0d,%0d, required 3,7", pos1, pos2);
        end
    endtask

    task automatic test_abort_write();
        wb_adr_i = 32'h0000_0048; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk);
        checks++;
        if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b1 || sram_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL abort_setup: ce_n=%b we_n=%b data=%h, required 0 1 12345678", sram_ce_n, sram_we_n, sram_data);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_ack_o, sram_ce_n, sram_we_n} !== 3'b011 || sram_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL abort_write: ack,ce,we=%b data=%h, required 011 high-Z", {wb_ack_o, sram_ce_n, sram_we_n}, sram_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wb_ack_o !== 1'b0 || mem[8'h12] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL abort_mem: ack=%b mem=%h, required 0 cafef00d", wb_ack_o, mem[8'h12]);
        end
    endtask

    task automatic test_reset_in_read2();
        wb_adr_i = 32'h0000_0040; wb_sel_i = 4'hF; wb_we_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({wb_ack_o, sram_ce_n, sram_oe_n, sram_we_n} !== 4'b0111 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_read2: ack,ce,oe,we=%b dat_o=%h, required 0111 0", {wb_ack_o, sram_ce_n, sram_oe_n, sram_we_n}, wb_dat_o);
        end
        checks++;
        if (sram_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rst_read2_bus: sram_data=%h, required high-Z", sram_data);
        end
        rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        wb_cycle(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        checks++;
        if (edges !== 3 || rdata !== 32'h1122_33AB) begin
            errors++;
            $display("FAIL rst_recover: ack_edge=%0d dat_o=%h, required 3 112233ab", edges, rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h11] = 32'h1122_3344;
        mem[8'h12] = 32'hCAFE_F00D;
        mem[8'h13] = 32'h0BAD_F00D;
        test_reset();
        test_read();
        test_byte_write();
        test_sel_zero();
        test_back_to_back();
        test_abort_write();
        test_reset_in_read2();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
